// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register-command path (packer and sequencer).
package uart_reg_pkg;

  // Packer states, one-hot in a 5-bit field
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_RECV = 5'b00010,
    S_CSUM = 5'b00100
  } state_e;

  // Clock cycles per millisecond at 50 MHz
  localparam int MS_CNT_DEF = 50_000;

  // Command headers understood by the delay/wait sequencer
  localparam logic [15:0] DELAY_HEADER = 16'hABCD;
  localparam logic [15:0] WAIT_HEADER  = 16'hABC1;

  // XOR of the four bytes of a word (checksum byte value)
  function automatic logic [7:0] word_xor(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage

// File: rtl/uart_reg_pack_module_uart_ms_timer.sv
// Millisecond tick generator plus elapsed-ms gap counter.
// Holding clear high keeps both counters at zero.
module uart_ms_timer
  import uart_reg_pkg::*;
#(
  parameter int MS_CNT = MS_CNT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  output logic        ms_tick,
  output logic [15:0] gap_ms
);

  localparam int TW = (MS_CNT > 1) ? $clog2(MS_CNT) : 1;

  logic [TW-1:0] tick_q, tick_d;
  logic [15:0]   gap_q, gap_d;

  // Tick counter wraps at MS_CNT-1; each wrap adds one ms to the gap (saturating)
  always_comb begin
    tick_d  = tick_q;
    gap_d   = gap_q;
    ms_tick = !clear && (tick_q == TW'(MS_CNT - 1));
    if (clear) begin
      tick_d = '0;
      gap_d  = '0;
    end else if (ms_tick) begin
      tick_d = '0;
      if (gap_q != 16'hFFFF) gap_d = gap_q + 16'd1;
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      gap_q  <= '0;
    end else begin
      tick_q <= tick_d;
      gap_q  <= gap_d;
    end
  end

  assign gap_ms = gap_q;

endmodule

// File: rtl/uart_reg_pack_module.sv
// Packs received UART bytes (MSB first) into 32-bit register words and
// pushes them to the register FIFO with a one-cycle valid strobe.
// Inter-byte timeout discards partial words; full-FIFO drops are counted.
// Optional macro UART_REG_CHECKSUM_EN: a 5th byte (XOR of the data bytes)
// must follow each word before it is emitted.
module uart_reg_pack_module
  import uart_reg_pkg::*;
#(
  parameter int          MS_CNT     = MS_CNT_DEF,
  parameter logic [15:0] TIMEOUT_MS = 16'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        fifo_full,
  output logic [31:0] reg_out,
  output logic        reg_valid,
  output logic        frame_err,
  output logic [15:0] drop_cnt
);

  state_e      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [31:0] reg_out_q, reg_out_d;
  logic        reg_valid_q, reg_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        tmr_clear;
  logic        ms_tick;
  logic [15:0] gap_ms;
  logic        timeout;
  logic [31:0] word_next;

  // Gap timing only runs while a partial word is held; any byte restarts it
  assign tmr_clear = (state_q == S_IDLE) || rx_valid;

  uart_ms_timer #(.MS_CNT(MS_CNT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .ms_tick (ms_tick),
    .gap_ms  (gap_ms)
  );

  // Fires on the tick that brings the gap up to TIMEOUT_MS
  assign timeout   = (TIMEOUT_MS != 16'd0) && ms_tick &&
                     (gap_ms == TIMEOUT_MS - 16'd1);
  assign word_next = {shreg_q[23:0], rx_data};

  // Next-state, packing, emit and drop accounting
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shreg_d     = shreg_q;
    reg_out_d   = reg_out_q;
    reg_valid_d = 1'b0;
    frame_err_d = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          shreg_d    = word_next;
          byte_cnt_d = 3'd1;
          state_d    = S_RECV;
        end
      end
      S_RECV: begin
        // A byte arriving with the timeout wins over the timeout
        if (rx_valid) begin
          shreg_d    = word_next;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd3) begin
`ifdef UART_REG_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d    = S_IDLE;
            byte_cnt_d = 3'd0;
            if (!fifo_full) begin
              reg_out_d   = word_next;
              reg_valid_d = 1'b1;
            end else if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
`endif
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
          byte_cnt_d  = 3'd0;
          shreg_d     = '0;
        end
      end
`ifdef UART_REG_CHECKSUM_EN
      S_CSUM: begin
        // The checksum byte is compared, never shifted into the word
        if (rx_valid) begin
          state_d    = S_IDLE;
          byte_cnt_d = 3'd0;
          if (rx_data == word_xor(shreg_q)) begin
            if (!fifo_full) begin
              reg_out_d   = shreg_q;
              reg_valid_d = 1'b1;
            end else if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_d = drop_cnt_q + 16'd1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
          byte_cnt_d  = 3'd0;
          shreg_d     = '0;
        end
      end
`endif
      default: begin
        state_d    = S_IDLE;
        byte_cnt_d = 3'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      shreg_q     <= '0;
      reg_out_q   <= '0;
      reg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shreg_q     <= shreg_d;
      reg_out_q   <= reg_out_d;
      reg_valid_q <= reg_valid_d;
      frame_err_q <= frame_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign reg_out   = reg_out_q;
  assign reg_valid = reg_valid_q;
  assign frame_err = frame_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
